booth_seq_mult_ctrl: RTL and testbench

- Sequential radix-2 Booth signed multiplier.
- Instead of one unrolled add/shift stage per bit, it reuses a single add/subtract/arith-shift stage and steps it once per clock under FSM control.
- Sits beside the combinational multiplier as the area-reduced variant: same signed operand semantics, same out/cout result format, plus a start/busy/done handshake.

---
 rtl/booth_seq_mult_ctrl.sv | 113 +++++++++++
 tb/tb_booth_seq_mult_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult_ctrl.sv
// Sequential radix-2 Booth signed multiplier.
// One add/sub + arithmetic-shift step per clock, start/busy/done handshake.
module booth_seq_mult_ctrl #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] prod,
  output logic [W-1:0]   out,
  output logic           cout
);

  localparam int CW = $clog2(W + 1);
  localparam int PW = 2 * W + 2;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t         r_state, w_state_nx;
  logic [PW-1:0]  r_p, w_p_nx, w_step;
  logic [W:0]     r_am, r_sm, w_am_nx, w_sm_nx;
  logic [W:0]     w_acc, w_ext;
  logic [CW-1:0]  r_cnt, w_cnt_nx;
  logic [2*W-1:0] r_prod, w_prod_nx, w_pnew;
  logic           r_done, w_done_nx;
  logic           r_cout, w_cout_nx;
  logic           w_last, w_fit;

  // Extra acc bit lets -2^(W-1) negate without overflow
  assign w_ext = {a[W-1], a};

  always_comb begin
    unique case (r_p[1:0])
      2'b01:   w_acc = r_p[PW-1:W+1] + r_am;
      2'b10:   w_acc = r_p[PW-1:W+1] + r_sm;
      default: w_acc = r_p[PW-1:W+1];
    endcase
    w_step = {w_acc[W], w_acc, r_p[W:1]};
  end

  assign w_pnew = w_step[2*W:1];
  assign w_fit  = (&w_pnew[2*W-1:W-1]) | ~(|w_pnew[2*W-1:W-1]);
  assign w_last = (r_cnt == CW'(W - 1));

  always_comb begin
    w_state_nx = r_state;
    w_p_nx     = r_p;
    w_am_nx    = r_am;
    w_sm_nx    = r_sm;
    w_cnt_nx   = r_cnt;
    w_done_nx  = 1'b0;
    w_prod_nx  = r_prod;
    w_cout_nx  = r_cout;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_am_nx    = w_ext;
          w_sm_nx    = (W+1)'(0) - w_ext;
          w_p_nx     = {(W+1)'(0), b, 1'b0};
          w_cnt_nx   = '0;
          w_state_nx = RUN;
        end
      end
      RUN: begin
        w_p_nx   = w_step;
        w_cnt_nx = r_cnt + CW'(1);
        if (w_last) begin
          w_state_nx = IDLE;
          w_done_nx  = 1'b1;
          w_prod_nx  = w_pnew;
          w_cout_nx  = ~w_fit;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_p     <= '0;
      r_am    <= '0;
      r_sm    <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_prod  <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_p     <= w_p_nx;
      r_am    <= w_am_nx;
      r_sm    <= w_sm_nx;
      r_cnt   <= w_cnt_nx;
      r_done  <= w_done_nx;
      r_prod  <= w_prod_nx;
      r_cout  <= w_cout_nx;
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign prod = r_prod;
  assign out  = r_prod[W-1:0];
  assign cout = r_cout;

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Bench for booth_seq_mult_ctrl: directed table at W=4, handshake corners,
// exhaustive W=4 back-to-back sweep and random W=8 sweep.
module tb_booth_seq_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        s4, s8;
  logic [3:0]  a4, b4, out4;
  logic [7:0]  a8, b8, out8, prod4;
  logic [15:0] prod8;
  logic        busy4, done4, cout4;
  logic        busy8, done8, cout8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_seq_mult_ctrl #(.W(4)) u4 (
    .clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .prod(prod4), .out(out4), .cout(cout4)
  );

  booth_seq_mult_ctrl #(.W(8)) u8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .prod(prod8), .out(out8), .cout(cout8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    logic       c;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pulse start for one cycle, then wait (bounded) for done.
  task automatic op4(input logic [3:0] a, input logic [3:0] b,
                     output int lat, output int bc);
    @(negedge clk);
    s4 = 1'b1; a4 = a; b4 = b;
    @(negedge clk);
    s4 = 1'b0;
    lat = 1;
    bc = 0;
    while (!done4 && lat < 20) begin
      if (busy4) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bc, nd, c;
    logic signed [7:0]  e4;
    logic signed [15:0] e8;
    logic [3:0] pa, pb;

    tv[0] = '{4'h3, 4'h2, 8'h06, 1'b0};
    tv[1] = '{4'h8, 4'h8, 8'h40, 1'b1};
    tv[2] = '{4'h8, 4'h1, 8'hF8, 1'b0};
    tv[3] = '{4'hF, 4'hF, 8'h01, 1'b0};
    tv[4] = '{4'h5, 4'hD, 8'hF1, 1'b1};
    tv[5] = '{4'h7, 4'h7, 8'h31, 1'b1};
    tv[6] = '{4'h0, 4'h5, 8'h00, 1'b0};
    tv[7] = '{4'h7, 4'h8, 8'hC8, 1'b1};
    tv[8] = '{4'h2, 4'hE, 8'hFC, 1'b0};

    rst = 1'b1; s4 = 1'b0; s8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy4), 0);
    chk("rst_done", 32'(done4), 0);
    chk("rst_prod", 32'(prod4), 0);
    chk("rst_cout", 32'(cout4), 0);
    chk("rst_prod8", 32'(prod8), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      op4(tv[i].a, tv[i].b, lat, bc);
      chk("tbl_lat", 32'(lat), 5);
      chk("tbl_busy_cycles", 32'(bc), 4);
      chk("tbl_busy_at_done", 32'(busy4), 0);
      chk("tbl_prod", 32'(prod4), 32'(tv[i].p));
      chk("tbl_out", 32'(out4), 32'(tv[i].p[3:0]));
      chk("tbl_cout", 32'(cout4), 32'(tv[i].c));
      @(negedge clk);
      chk("tbl_done_drop", 32'(done4), 0);
      chk("tbl_prod_hold", 32'(prod4), 32'(tv[i].p));
    end

    // start while busy is ignored
    @(negedge clk);
    s4 = 1'b1; a4 = 4'h3; b4 = 4'h2;
    @(negedge clk);
    a4 = 4'h7; b4 = 4'h7;
    @(negedge clk);
    @(negedge clk);
    s4 = 1'b0;
    lat = 3;
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_ign_lat", 32'(lat), 5);
    chk("busy_ign_prod", 32'(prod4), 32'h06);
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done4) nd++;
    end
    chk("busy_ign_extra_done", 32'(nd), 0);

    // start held across the done cycle: back-to-back
    @(negedge clk);
    s4 = 1'b1; a4 = 4'h2; b4 = 4'h3;
    @(negedge clk);
    a4 = 4'h5; b4 = 4'hD;
    lat = 1;
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_lat1", 32'(lat), 5);
    chk("b2b_prod1", 32'(prod4), 32'h06);
    @(negedge clk);
    s4 = 1'b0;
    chk("b2b_busy2", 32'(busy4), 1);
    lat = 1;
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_lat2", 32'(lat), 5);
    chk("b2b_prod2", 32'(prod4), 32'hF1);
    chk("b2b_cout2", 32'(cout4), 1);
    @(negedge clk);

    // reset mid-run at cnt=2
    @(negedge clk);
    s4 = 1'b1; a4 = 4'h3; b4 = 4'h3;
    @(negedge clk);
    s4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_prod_held", 32'(prod4), 32'hF1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy4), 0);
    chk("abort_done", 32'(done4), 0);
    chk("abort_prod", 32'(prod4), 0);
    chk("abort_cout", 32'(cout4), 0);
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done4) nd++;
    end
    chk("abort_no_done", 32'(nd), 0);
    op4(4'hE, 4'h3, lat, bc);
    chk("post_abort_lat", 32'(lat), 5);
    chk("post_abort_prod", 32'(prod4), 32'hFA);
    chk("post_abort_cout", 32'(cout4), 0);
    @(negedge clk);

    // exhaustive W=4, back-to-back
    @(negedge clk);
    s4 = 1'b1; a4 = 4'h0; b4 = 4'h0;
    @(negedge clk);
    {a4, b4} = 8'd1;
    for (int i = 0; i < 256; i++) begin
      lat = 1;
      while (!done4 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      {pa, pb} = 8'(i);
      e4 = $signed(pa) * $signed(pb);
      chk("sweep4_lat", 32'(lat), 5);
      chk("sweep4_prod", 32'({prod4, cout4}),
          32'({e4, !(e4 >= -8 && e4 <= 7)}));
      if (i == 255) s4 = 1'b0;
      @(negedge clk);
      if (i + 2 <= 255) {a4, b4} = 8'(i + 2);
    end

    // random W=8
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      s8 = 1'b1;
      if (i == 0) begin
        a8 = 8'h80; b8 = 8'h80;
      end else if (i == 1) begin
        a8 = 8'h80; b8 = 8'h7F;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
      e8 = $signed(a8) * $signed(b8);
      @(negedge clk);
      s8 = 1'b0;
      c = 1;
      while (!done8 && c < 30) begin
        @(negedge clk);
        c++;
      end
      chk("rand8_lat", 32'(c), 9);
      chk("rand8_prod", 32'({prod8, cout8}),
          32'({e8, !(e8 >= -128 && e8 <= 127)}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
